// File: rtl/instr_memory_loader_pkg.sv
// instr_memory_loader_pkg: shared widths, loader FSM states and constants for the boot loader
package instr_memory_loader_pkg;
  localparam int InstructionSize = 32;
  localparam int LoaderHeaderBytes = 2;
  localparam logic [31:0] InstrNop = 32'h0000_0013;
  typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, RUN, ERROR} loader_state_t;
endpackage

// File: rtl/instr_memory_if.sv
// instr_memory_if: fetch port between core and instruction store (addr from core, instr from memory)
interface instr_memory_if #(
  parameter int AddrSize = 10,
  parameter int InstrSize = 32
);
  logic [AddrSize-1:0] addr;
  logic [InstrSize-1:0] instr;
  modport memory (input addr, output instr);
  modport core (output addr, input instr);
endinterface

// File: rtl/instr_ram.sv
// instr_ram: word RAM, sync write (clk, we, waddr, wdata) and async read (raddr -> rdata, old data on same-cycle write)
module instr_ram #(
  parameter int AddrWords = 256,
  parameter int Width = 32
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(AddrWords)-1:0] waddr,
  input  logic [Width-1:0]             wdata,
  input  logic [$clog2(AddrWords)-1:0] raddr,
  output logic [Width-1:0]             rdata
);
  logic [Width-1:0] mem [AddrWords];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_memory_loader.sv
// instr_memory_loader: byte-stream boot loader + instruction store; ports clk, rst_n, instr_mem_if (fetch), load_valid/load_data/load_ready (image bytes), core_rst, load_done, load_error
module instr_memory_loader
  import instr_memory_loader_pkg::*;
#(
  parameter int AddrSize = 10,
  parameter int InstrSize = InstructionSize
) (
  input  logic                   clk,
  input  logic                   rst_n,
  instr_memory_if.memory         instr_mem_if,
  input  logic                   load_valid,
  input  logic [7:0]             load_data,
  output logic                   load_ready,
  output logic                   core_rst,
  output logic                   load_done,
  output logic                   load_error
);
  localparam int WordBits = AddrSize - 2;
  localparam int Depth = 2 ** WordBits;
  loader_state_t state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [1:0] cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d;
  logic [WordBits-1:0] widx_q, widx_d;
  logic xfer, we;
  logic unused_addr_bits;
  assign unused_addr_bits = ^instr_mem_if.addr[1:0];
  assign load_ready = rst_n && (state_q inside {HDR_LO, HDR_HI, DATA});
  assign xfer = load_valid && load_ready;
  assign we = xfer && state_q == DATA && cnt_q == 2'd3;
  assign core_rst = state_q != RUN;
  assign load_done = state_q == RUN;
  assign load_error = state_q == ERROR;
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    cnt_d = cnt_q;
    sr_d = sr_q;
    widx_d = widx_q;
    if (xfer) begin
      case (state_q)
        HDR_LO: begin
          n_d = {8'h00, load_data};
          state_d = HDR_HI;
        end
        HDR_HI: begin
          n_d = {load_data, n_q[7:0]};
          state_d = n_d == 16'd0 ? RUN : 32'(n_d) > Depth ? ERROR : DATA;
        end
        DATA: begin
          cnt_d = cnt_q + 2'd1;
          sr_d = {load_data, sr_q[23:8]};
          if (cnt_q == 2'd3) begin
            widx_d = widx_q + WordBits'(1);
            state_d = 32'(widx_q) == 32'(n_q) - 32'd1 ? RUN : DATA;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HDR_LO;
      n_q <= '0;
      cnt_q <= '0;
      sr_q <= '0;
      widx_q <= '0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      widx_q <= widx_d;
    end
  end
  instr_ram #(.AddrWords(Depth), .Width(InstrSize)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (widx_q),
    .wdata ({load_data, sr_q}),
    .raddr (instr_mem_if.addr[AddrSize-1:2]),
    .rdata (instr_mem_if.instr)
  );
endmodule
